// File: rtl/noc_pkg.sv
// +----------------------------------------------------------------------+
// | noc_pkg: shared types and helpers for the NoC router node.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package noc_pkg;

    localparam int FLIT_WIDTH = 16;
    localparam int MAX_PORTS  = 8;
    localparam int PORT_IDX_W = 3;
    localparam int DROP_CNT_W = 16;

    typedef logic [FLIT_WIDTH-1:0] flit_t;

    typedef struct packed {
        logic                  any;
        logic [PORT_IDX_W-1:0] idx;
    } rr_pick_t;

    // Generic field extraction so the router can override flit geometry.
    function automatic logic [7:0] dest_of(input logic [63:0] flit,
                                           input int unsigned lsb,
                                           input int unsigned width);
        logic [63:0] shifted;
        logic [63:0] mask;
        shifted = flit >> lsb;
        mask    = (64'd1 << width) - 64'd1;
        return 8'(shifted & mask);
    endfunction

    // First requester at or after ptr, scanning modulo n.
    function automatic rr_pick_t rr_pick(input logic [MAX_PORTS-1:0]  req,
                                         input logic [PORT_IDX_W-1:0] ptr,
                                         input int unsigned           n);
        rr_pick_t    res;
        int unsigned cand;
        res = '0;
        for (int unsigned k = 0; k < MAX_PORTS; k++) begin
            cand = (32'(ptr) + k) % n;
            if (k < n && !res.any && req[cand[PORT_IDX_W-1:0]]) begin
                res.any = 1'b1;
                res.idx = cand[PORT_IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/noc_router_node_if.sv
// +----------------------------------------------------------------------+
// | noc_router_node_if: flit ingress/egress bundle for the router node.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface noc_router_node_if #(
    parameter int NUM_PORTS  = 5,
    parameter int DATA_WIDTH = 16
);
    logic [NUM_PORTS-1:0]            in_valid;
    logic [NUM_PORTS*DATA_WIDTH-1:0] in_data;
    logic [NUM_PORTS-1:0]            in_full;
    logic [NUM_PORTS-1:0]            out_valid;
    logic [NUM_PORTS*DATA_WIDTH-1:0] out_data;
    logic [NUM_PORTS-1:0]            out_full;

    modport slave (
        input  in_valid, in_data, out_full,
        output in_full, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_full,
        input  in_full, out_valid, out_data
    );
endinterface

`default_nettype wire

// File: rtl/router_fifo.sv
// +----------------------------------------------------------------------+
// | router_fifo: per-input flit FIFO with combinational head output.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module router_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push,
    input  wire logic             pop,
    input  wire logic [WIDTH-1:0] din,
    output logic      [WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             w_do_push, w_do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign dout     = mem_q[rd_ptr_q];
    // Fullness is judged before any same-cycle pop frees a slot.
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign overflow  = push && full;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (w_do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q] <= din;
    end
endmodule

`default_nettype wire

// File: rtl/noc_router_node.sv
// +----------------------------------------------------------------------+
// | noc_router_node: N-port single-flit router, per-output RR arbiters.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module noc_router_node
    import noc_pkg::*;
#(
    parameter int NUM_PORTS  = 5,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int DEST_LSB   = 12,
    parameter int DEST_WIDTH = 3
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    noc_router_node_if.slave           bus,
    output logic [DROP_CNT_W-1:0]      drop_count,
    output logic                       overflow_err
);
    logic [DATA_WIDTH-1:0]           w_head [NUM_PORTS];
    logic [NUM_PORTS-1:0]            w_empty, w_full, w_ovf, w_pop, w_drop;
    logic [MAX_PORTS-1:0]            w_req [NUM_PORTS];
    logic [NUM_PORTS-1:0]            w_out_valid;
    logic [NUM_PORTS*DATA_WIDTH-1:0] w_out_data;
    logic [PORT_IDX_W-1:0]           rr_q [NUM_PORTS];
    logic [PORT_IDX_W-1:0]           rr_d [NUM_PORTS];
    logic [DROP_CNT_W-1:0]           drop_count_q, drop_count_d;
    logic                            overflow_err_q, overflow_err_d;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_fifo
        router_fifo #(
            .WIDTH (DATA_WIDTH),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (bus.in_valid[gi]),
            .pop      (w_pop[gi]),
            .din      (bus.in_data[gi*DATA_WIDTH +: DATA_WIDTH]),
            .dout     (w_head[gi]),
            .full     (w_full[gi]),
            .empty    (w_empty[gi]),
            .overflow (w_ovf[gi])
        );
    end

    assign bus.in_full   = w_full;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_data;
    assign drop_count    = drop_count_q;
    assign overflow_err  = overflow_err_q;

    // Heads with a bad or U-turn destination are dropped; the rest request.
    always_comb begin
        logic [7:0] dest;
        dest   = '0;
        w_drop = '0;
        for (int j = 0; j < NUM_PORTS; j++) w_req[j] = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            dest = dest_of(64'(w_head[i]), DEST_LSB, DEST_WIDTH);
            if (!w_empty[i]) begin
                if (32'(dest) >= NUM_PORTS || 32'(dest) == i) begin
                    w_drop[i] = 1'b1;
                end else begin
                    for (int j = 0; j < NUM_PORTS; j++) begin
                        if (32'(dest) == j) w_req[j][i] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        rr_pick_t pick;
        pick        = '0;
        w_pop       = w_drop;
        w_out_valid = '0;
        w_out_data  = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            rr_d[j] = rr_q[j];
            if (!bus.out_full[j]) begin
                pick = rr_pick(w_req[j], rr_q[j], NUM_PORTS);
                if (pick.any) begin
                    w_out_valid[j]                         = 1'b1;
                    w_out_data[j*DATA_WIDTH +: DATA_WIDTH] = w_head[pick.idx];
                    w_pop[pick.idx]                        = 1'b1;
                    rr_d[j] = (32'(pick.idx) == NUM_PORTS - 1) ? '0
                                                               : pick.idx + PORT_IDX_W'(1);
                end
            end
        end
    end

    // Several inputs may drop in one cycle; accumulate wide, then clamp.
    always_comb begin
        logic [DROP_CNT_W:0] sum;
        sum = {1'b0, drop_count_q};
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_drop[i]) sum = sum + (DROP_CNT_W+1)'(1);
        end
        drop_count_d   = sum[DROP_CNT_W] ? '1 : sum[DROP_CNT_W-1:0];
        overflow_err_d = overflow_err_q | (|w_ovf);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < NUM_PORTS; j++) rr_q[j] <= '0;
            drop_count_q   <= '0;
            overflow_err_q <= 1'b0;
        end else begin
            for (int j = 0; j < NUM_PORTS; j++) rr_q[j] <= rr_d[j];
            drop_count_q   <= drop_count_d;
            overflow_err_q <= overflow_err_d;
        end
    end
endmodule

`default_nettype wire
